// File: rtl/timer_controller.sv
// Programmable interval timer: a prescaler and a main down-counter sequenced by
// a two-state controller, with a sticky expiry interrupt and an overrun flag.

// Loadable down-counter with an active-high synchronous clear.
module sync_parallel_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  // Clear beats load, load beats decrement.
  always_ff @(posedge clock) begin
    if (rst)       q <= '0;
    else if (load) q <= din;
    else if (dec)  q <= q - WIDTH'(1);
  end

endmodule

module timer_controller #(
  parameter int DATA_SIZE      = 16,
  parameter int PRESCALER_SIZE = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      periodic,
  input  logic [DATA_SIZE-1:0]      period,
  input  logic [PRESCALER_SIZE-1:0] prescale,
  input  logic                      irq_ack,
  output logic                      busy,
  output logic                      irq,
  output logic                      overrun,
  output logic [DATA_SIZE-1:0]      count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [DATA_SIZE-1:0]      period_r;
  logic [PRESCALER_SIZE-1:0] prescale_r;
  logic                      periodic_r;

  logic [DATA_SIZE-1:0]      cnt_q, cnt_din;
  logic [PRESCALER_SIZE-1:0] pre_q, pre_din;
  logic                      cnt_load, cnt_dec, pre_load, pre_dec;
  logic                      start_ok, start_acc, fire;
  logic                      counter_rst;

  // A zero period would expire immediately, so such a start is ignored.
  assign start_ok    = start && (period != '0);
  assign counter_rst = ~reset;

  sync_parallel_counter #(.WIDTH(PRESCALER_SIZE)) u_prescaler (
    .clock (clock),
    .rst   (counter_rst),
    .load  (pre_load),
    .dec   (pre_dec),
    .din   (pre_din),
    .q     (pre_q)
  );

  sync_parallel_counter #(.WIDTH(DATA_SIZE)) u_main (
    .clock (clock),
    .rst   (counter_rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .din   (cnt_din),
    .q     (cnt_q)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and counter sequencing; stop beats start beats tick.
  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_din   = period;
    pre_load  = 1'b0;
    pre_dec   = 1'b0;
    pre_din   = prescale;
    start_acc = 1'b0;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          start_acc = 1'b1;
          cnt_load  = 1'b1;
          pre_load  = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d  = IDLE;
          cnt_load = 1'b1;
          cnt_din  = '0;
          pre_load = 1'b1;
          pre_din  = '0;
        end else if (start_ok) begin
          start_acc = 1'b1;
          cnt_load  = 1'b1;
          pre_load  = 1'b1;
        end else if (pre_q == '0) begin
          pre_load = 1'b1;
          pre_din  = prescale_r;
          if (cnt_q == DATA_SIZE'(1)) begin
            fire = 1'b1;
            if (periodic_r) begin
              cnt_load = 1'b1;
              cnt_din  = period_r;
            end else begin
              cnt_dec = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end else begin
          pre_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Configuration captured only on an accepted start; meaningless until then.
  always_ff @(posedge clock) begin
    if (start_acc) begin
      period_r   <= period;
      prescale_r <= prescale;
      periodic_r <= periodic;
    end
  end

  // Sticky flags: an expiry wins over a same-cycle ack and is not an overrun.
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (fire)         irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
      if (fire && irq && !irq_ack) overrun <= 1'b1;
      else if (start_acc)          overrun <= 1'b0;
    end
  end

  assign busy  = (state_q == RUN);
  assign count = cnt_q;

endmodule
